// File: rtl/mem_pkg.sv
// Shared types and address-map constants for the data-memory responder.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    typedef enum logic [1:0] {
        RAM,
        CYC,
        LED,
        BAD
    } acc_cls_e;

    localparam logic [31:0] DEF_BASE_ADDR = 32'h1001_0000;
    localparam logic [31:0] DEF_MMIO_BASE = 32'hFFFF_0000;

    localparam logic [31:0] MMIO_CYCLES = 32'd0;
    localparam logic [31:0] MMIO_LEDS   = 32'd4;

endpackage

// File: rtl/byte_en_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// Read data appears the cycle after re_i and holds until the next read.
module byte_en_ram #(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           we_i,
    input  logic                           re_i,
    input  logic [3:0]                     be_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
    input  logic [31:0]                    wdata_i,
    output logic [31:0]                    rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory end of the core's load/store port: req/ack handshake, WAIT_STATES+1 cycle
// latency (errors answer after one), byte-enable RAM, cycle counter and LED register.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
    parameter logic [31:0] MMIO_BASE   = DEF_MMIO_BASE,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err,
    output logic [7:0]  leds
);

    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);

    state_e      state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    acc_cls_e    cls_q, cls_d;
    logic [7:0]  leds_q, leds_d;
    logic [31:0] cyc_q;
    logic [31:0] mmio_q, mmio_d;
    logic        commit;
    logic        ram_we, ram_re;
    logic [AW-1:0] ram_idx;
    logic [31:0] ram_rdata;

    function automatic acc_cls_e classify(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        if (a[1:0] != 2'b00)                  return BAD;
        if (a >= BASE_ADDR && off < RAM_BYTES) return RAM;
        if (a == MMIO_BASE + MMIO_CYCLES)      return CYC;
        if (a == MMIO_BASE + MMIO_LEDS)        return LED;
        return BAD;
    endfunction

    // The _d access fields carry live inputs in IDLE and latched ones in WAIT, so the
    // commit below works the same whether RESP is entered from IDLE or WAIT.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        cls_d   = cls_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d  = addr;
                    we_d    = we;
                    wdata_d = wdata;
                    be_d    = be;
                    cls_d   = classify(addr);
                    if (cls_d == BAD || WAIT_STATES == 0) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        wait_d  = 4'(WAIT_STATES - 1);
                    end
                end
            end
            WAIT: begin
                if (wait_q == 4'd0) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Reset abandons an in-flight access, so no side effect may leak out on that edge.
    always_comb begin
        ram_we  = commit && !reset && cls_d == RAM && we_d;
        ram_re  = commit && !reset && cls_d == RAM && !we_d;
        ram_idx = AW'((addr_d - BASE_ADDR) >> 2);
        leds_d  = leds_q;
        if (commit && cls_d == LED && we_d && be_d[0]) begin
            leds_d = wdata_d[7:0];
        end
        mmio_d = mmio_q;
        if (commit) begin
            mmio_d = 32'd0;
            if (!we_d && cls_d == CYC) mmio_d = cyc_q;
            if (!we_d && cls_d == LED) mmio_d = {24'd0, leds_q};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            wait_q  <= 4'd0;
            addr_q  <= 32'd0;
            we_q    <= 1'b0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            cls_q   <= RAM;
            leds_q  <= 8'd0;
            cyc_q   <= 32'd0;
            mmio_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            cls_q   <= cls_d;
            leds_q  <= leds_d;
            cyc_q   <= cyc_q + 32'd1;
            mmio_q  <= mmio_d;
        end
    end

    byte_en_ram #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .be_i    (be_d),
        .addr_i  (ram_idx),
        .wdata_i (wdata_d),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        ack   = (state_q == RESP);
        err   = ack && (cls_q == BAD);
        rdata = 32'd0;
        if (ack && cls_q == RAM && !we_q) rdata = ram_rdata;
        else if (ack)                     rdata = mmio_q;
    end

    assign leds = leds_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboarded bench: u_dut runs with two wait states, u_dut0 with none for back-to-back traffic.
module tb_data_mem_responder;

    localparam int          WS        = 2;
    localparam logic [31:0] MMIO_BASE = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        req, we;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic        ack, err;
    logic [31:0] rdata;
    logic [7:0]  leds;

    logic        req0, we0;
    logic [31:0] addr0, wdata0;
    logic [3:0]  be0;
    logic        ack0, err0;
    logic [31:0] rdata0;
    logic [7:0]  leds0;

    int checks   = 0;
    int failures = 0;
    logic [31:0] tb_cyc;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [7:0]  lat;
    } exp_t;
    exp_t sb[$];

    data_mem_responder #(.WAIT_STATES(WS)) u_dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .be(be), .ack(ack), .rdata(rdata), .err(err), .leds(leds)
    );

    data_mem_responder #(.WAIT_STATES(0)) u_dut0 (
        .clk(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
        .be(be0), .ack(ack0), .rdata(rdata0), .err(err0), .leds(leds0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) tb_cyc <= 32'd0;
        else       tb_cyc <= tb_cyc + 32'd1;
    end

    // Issue one request on u_dut from a falling edge; lat = 0 means no ack within budget.
    task automatic run_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] b, output logic [31:0] o_rdata,
                           output logic o_err, output logic [7:0] o_leds, output int o_lat);
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
        o_lat = 0; o_rdata = 32'hxxxx_xxxx; o_err = 1'bx; o_leds = 8'hxx;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (ack) begin
                o_lat = i; o_rdata = rdata; o_err = err; o_leds = leds;
                break;
            end
        end
        req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0; be = 4'd0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (ack !== 1'b0)       begin failures++; $display("FAIL reset_ack got %b want 0", ack); end
        checks++; if (err !== 1'b0)       begin failures++; $display("FAIL reset_err got %b want 0", err); end
        checks++; if (rdata !== 32'd0)    begin failures++; $display("FAIL reset_rdata got %h want 0", rdata); end
        checks++; if (leds !== 8'd0)      begin failures++; $display("FAIL reset_leds got %h want 0", leds); end
        checks++; if (ack0 !== 1'b0)      begin failures++; $display("FAIL reset_ack0 got %b want 0", ack0); end
    endtask

    task automatic test_counter();
        logic [31:0] r; logic e; logic [7:0] l; int lat; exp_t x;
        sb.push_back('{rdata: tb_cyc + WS, err: 1'b0, lat: 8'(WS + 1)});
        run_req(1'b0, MMIO_BASE, 32'd0, 4'hF, r, e, l, lat);
        x = sb.pop_front();
        checks++; if (r !== x.rdata)   begin failures++; $display("FAIL cyc_rdata got %h want %h", r, x.rdata); end
        checks++; if (e !== x.err)     begin failures++; $display("FAIL cyc_err got %b want %b", e, x.err); end
        checks++; if (lat !== int'(x.lat)) begin failures++; $display("FAIL cyc_lat got %0d want %0d", lat, x.lat); end
        sb.push_back('{rdata: tb_cyc + WS, err: 1'b0, lat: 8'(WS + 1)});
        run_req(1'b1, MMIO_BASE, 32'h5555_5555, 4'hF, r, e, l, lat);
        run_req(1'b0, MMIO_BASE, 32'd0, 4'hF, r, e, l, lat);
        x = sb.pop_front();
        checks++; if (r !== x.rdata + 32'd4) begin failures++; $display("FAIL cyc_ro got %h want %h", r, x.rdata + 32'd4); end
    endtask

    task automatic test_store_load();
        logic [31:0] r; logic e; logic [7:0] l; int lat; exp_t x;
        run_req(1'b1, 32'h1001_0008, 32'hDEAD_BEEF, 4'hF, r, e, l, lat);
        checks++; if (lat !== WS + 1) begin failures++; $display("FAIL st_lat got %0d want %0d", lat, WS + 1); end
        checks++; if (e !== 1'b0)     begin failures++; $display("FAIL st_err got %b want 0", e); end
        sb.push_back('{rdata: 32'hDEAD_BEEF, err: 1'b0, lat: 8'(WS + 1)});
        run_req(1'b0, 32'h1001_0008, 32'd0, 4'h0, r, e, l, lat);
        x = sb.pop_front();
        checks++; if (r !== x.rdata)       begin failures++; $display("FAIL ld_rdata got %h want %h", r, x.rdata); end
        checks++; if (e !== x.err)         begin failures++; $display("FAIL ld_err got %b want %b", e, x.err); end
        checks++; if (lat !== int'(x.lat)) begin failures++; $display("FAIL ld_lat got %0d want %0d", lat, x.lat); end
    endtask

    task automatic test_partial();
        logic [31:0] r; logic e; logic [7:0] l; int lat; exp_t x;
        run_req(1'b1, 32'h1001_0000, 32'hFFFF_FFFF, 4'hF, r, e, l, lat);
        run_req(1'b1, 32'h1001_0000, 32'h1122_3344, 4'b0101, r, e, l, lat);
        run_req(1'b1, 32'h1001_0000, 32'h0000_0000, 4'b0000, r, e, l, lat);
        checks++; if (lat !== WS + 1) begin failures++; $display("FAIL be0_lat got %0d want %0d", lat, WS + 1); end
        sb.push_back('{rdata: 32'hFF22_FF44, err: 1'b0, lat: 8'(WS + 1)});
        run_req(1'b0, 32'h1001_0000, 32'd0, 4'h1, r, e, l, lat);
        x = sb.pop_front();
        checks++; if (r !== x.rdata) begin failures++; $display("FAIL partial_rdata got %h want %h", r, x.rdata); end
    endtask

    task automatic test_errors();
        logic [31:0] r; logic e; logic [7:0] l; int lat; exp_t x;
        sb.push_back('{rdata: 32'd0, err: 1'b1, lat: 8'd1});
        run_req(1'b0, 32'h1001_0002, 32'd0, 4'hF, r, e, l, lat);
        x = sb.pop_front();
        checks++; if (e !== x.err)         begin failures++; $display("FAIL mis_err got %b want %b", e, x.err); end
        checks++; if (r !== x.rdata)       begin failures++; $display("FAIL mis_rdata got %h want %h", r, x.rdata); end
        checks++; if (lat !== int'(x.lat)) begin failures++; $display("FAIL mis_lat got %0d want %0d", lat, x.lat); end
        run_req(1'b1, 32'h1001_1000, 32'h0BAD_0BAD, 4'hF, r, e, l, lat);
        checks++; if (e !== 1'b1) begin failures++; $display("FAIL oob_err got %b want 1", e); end
        checks++; if (lat !== 1)  begin failures++; $display("FAIL oob_lat got %0d want 1", lat); end
        run_req(1'b0, MMIO_BASE + 32'd8, 32'd0, 4'hF, r, e, l, lat);
        checks++; if (e !== 1'b1) begin failures++; $display("FAIL mmio_hole_err got %b want 1", e); end
        sb.push_back('{rdata: 32'hFF22_FF44, err: 1'b0, lat: 8'(WS + 1)});
        run_req(1'b0, 32'h1001_0000, 32'd0, 4'hF, r, e, l, lat);
        x = sb.pop_front();
        checks++; if (r !== x.rdata) begin failures++; $display("FAIL oob_ram_intact got %h want %h", r, x.rdata); end
    endtask

    task automatic test_leds();
        logic [31:0] r; logic e; logic [7:0] l; int lat; exp_t x;
        run_req(1'b1, MMIO_BASE + 32'd4, 32'h0000_00A5, 4'b0001, r, e, l, lat);
        checks++; if (l !== 8'hA5) begin failures++; $display("FAIL led_at_ack got %h want a5", l); end
        run_req(1'b1, MMIO_BASE + 32'd4, 32'h0000_003C, 4'b1110, r, e, l, lat);
        checks++; if (leds !== 8'hA5) begin failures++; $display("FAIL led_be0_off got %h want a5", leds); end
        sb.push_back('{rdata: 32'h0000_00A5, err: 1'b0, lat: 8'(WS + 1)});
        run_req(1'b0, MMIO_BASE + 32'd4, 32'd0, 4'h0, r, e, l, lat);
        x = sb.pop_front();
        checks++; if (r !== x.rdata) begin failures++; $display("FAIL led_load got %h want %h", r, x.rdata); end
        checks++; if (e !== x.err)   begin failures++; $display("FAIL led_err got %b want %b", e, x.err); end
    endtask

    task automatic test_reset_mid_store();
        logic [31:0] r; logic e; logic [7:0] l; int lat; exp_t x;
        logic saw_ack;
        run_req(1'b1, 32'h1001_0010, 32'h0000_0000, 4'hF, r, e, l, lat);
        saw_ack = 1'b0;
        req = 1'b1; we = 1'b1; addr = 32'h1001_0010; wdata = 32'h1234_5678; be = 4'hF;
        repeat (2) begin @(negedge clk); saw_ack |= ack; end
        reset = 1'b1; req = 1'b0;
        repeat (3) begin @(negedge clk); saw_ack |= ack; end
        reset = 1'b0;
        repeat (2) begin @(negedge clk); saw_ack |= ack; end
        checks++; if (saw_ack !== 1'b0) begin failures++; $display("FAIL abort_ack got %b want 0", saw_ack); end
        checks++; if (leds !== 8'd0)    begin failures++; $display("FAIL abort_leds got %h want 0", leds); end
        sb.push_back('{rdata: 32'd0, err: 1'b0, lat: 8'(WS + 1)});
        run_req(1'b0, 32'h1001_0010, 32'd0, 4'hF, r, e, l, lat);
        x = sb.pop_front();
        checks++; if (r !== x.rdata)       begin failures++; $display("FAIL abort_ram got %h want %h", r, x.rdata); end
        checks++; if (lat !== int'(x.lat)) begin failures++; $display("FAIL abort_lat got %0d want %0d", lat, x.lat); end
    endtask

    // Requests held continuously on the zero-wait instance: four stores then four loads.
    task automatic test_back_to_back();
        int   acks;
        exp_t x;
        acks = 0;
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h1001_0020; wdata0 = 32'hA000_0000; be0 = 4'hF;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            if (ack0) begin
                checks++;
                if (c % 2 != 1) begin failures++; $display("FAIL b2b_phase got ack at cycle %0d want odd cycle", c); end
                if (acks >= 4) begin
                    x = sb.pop_front();
                    checks++;
                    if (rdata0 !== x.rdata) begin failures++; $display("FAIL b2b_rdata got %h want %h", rdata0, x.rdata); end
                end
                acks++;
                if (acks < 4) begin
                    addr0 = 32'h1001_0020 + 32'(4 * acks); wdata0 = 32'hA000_0000 + 32'(acks);
                end else if (acks < 8) begin
                    we0 = 1'b0; addr0 = 32'h1001_0020 + 32'(4 * (acks - 4));
                    sb.push_back('{rdata: 32'hA000_0000 + 32'(acks - 4), err: 1'b0, lat: 8'd1});
                end else begin
                    req0 = 1'b0;
                end
            end
        end
        req0 = 1'b0;
        checks++; if (acks !== 8) begin failures++; $display("FAIL b2b_count got %0d want 8", acks); end
    endtask

    initial begin
        reset = 1'b1;
        req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0; be = 4'd0;
        req0 = 1'b0; we0 = 1'b0; addr0 = 32'd0; wdata0 = 32'd0; be0 = 4'd0;
        test_reset();
        test_counter();
        test_store_load();
        test_partial();
        test_errors();
        test_leds();
        test_reset_mid_store();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory responder for the MIPS core: the memory end of the load/store interface the datapath drives (ALU result as address, register rs2 value as write data, loaded word back to the write-back mux).
- Replaces the zero-latency memory with a req/ack handshake, programmable wait states, byte-enable writes, alignment/range error reporting and a small memory-mapped I/O window.
- Sits between the core's memory stage and the data RAM; the core stalls on req && !ack.

Parameters:
- DEPTH_WORDS, 1024: data RAM depth in 32-bit words (power of two).
- BASE_ADDR, 32'h10010000: byte address of RAM word 0.
- MMIO_BASE, 32'hFFFF0000: byte address of the MMIO window.
- WAIT_STATES, 2: extra cycles between request acceptance and ack (0..15).

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- reset, input, 1, synchronous active-high reset.
- req, input, 1, request valid; held high until ack.
- we, input, 1, 1 = store, 0 = load.
- addr, input, 32, byte address.
- wdata, input, 32, store data.
- be, input, 4, byte enables; be[0] selects wdata[7:0].
- ack, output, 1, one-cycle response strobe.
- rdata, output, 32, load data, valid only while ack = 1.
- err, output, 1, error flag, valid only while ack = 1.
- leds, output, 8, LED register contents.

Behaviour:
- Reset values: ack = 0, rdata = 0, err = 0, leds = 0, cycle counter = 0, FSM = IDLE. RAM contents are not reset.
- FSM states and transitions:
  - IDLE: when req = 1, latch addr/we/wdata/be and classify the access. Error -> RESP. Otherwise, WAIT_STATES = 0 -> RESP, else -> WAIT with wait counter = WAIT_STATES-1.
  - WAIT: decrement the wait counter; when it reaches 0 -> RESP. Inputs are ignored in WAIT.
  - RESP: ack = 1 for exactly one cycle -> IDLE. req sampled in RESP is ignored.
- Latency: ack is high in the cycle WAIT_STATES+1 after the edge that sampled req.
- Back-to-back: a new req is accepted in the IDLE cycle immediately after RESP, giving one request per WAIT_STATES+2 cycles.
- Access commit: the RAM write or register write takes effect at the edge entering RESP. Load data is captured at that same edge and is stable throughout the ack cycle.
- Classification, decided at acceptance:
  - addr[1:0] != 0 -> err.
  - BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH_WORDS -> RAM. Word index = (addr - BASE_ADDR) >> 2.
  - addr = MMIO_BASE + 0 -> cycle counter: read-only, store silently ignored, no err.
  - addr = MMIO_BASE + 4 -> LED register. Store writes leds from wdata[7:0] only if be[0]. Load returns {24'b0, leds}.
  - Any other address -> err.
- Error response: ack = 1, err = 1, rdata = 0; no state modified. The error path skips WAIT; ack comes one cycle after acceptance.
- Byte enables:
  - Store writes only the enabled bytes.
  - be = 4'b0000 store is a legal no-op and is acked normally.
  - Loads ignore be and return the full word.
- Cycle counter: 32-bit, increments every cycle from reset, wraps 32'hFFFFFFFF -> 0. A load returns the value held at the edge entering RESP.
- Reset mid-operation: reset has priority in every state. A store still in WAIT is abandoned with no write. ack is not asserted for the aborted request.
- rdata and err are 0 whenever ack = 0.

Decomposition:
- Shared package (mem_pkg):
  - FSM state enum: IDLE, WAIT, RESP.
  - Default BASE_ADDR and MMIO_BASE constants.
  - MMIO offset constants: MMIO_CYCLES = 0, MMIO_LEDS = 4.
  - Access-class enum: RAM, CYC, LED, BAD.
- One sub-module, byte_en_ram:
  - DEPTH_WORDS x 32 array.
  - Synchronous write with 4-bit byte enable.
  - Synchronous read of the addressed word.
  - Instantiated once. FSM, address decode and MMIO registers stay in the top module.

Test Plan:
- Reset, then idle 10 cycles -> ack/err/rdata/leds all 0; load from MMIO_BASE then returns the counter at the value the reference model predicts (monotonic, 0 at reset deassert).
- Store 32'hDEADBEEF to 32'h10010008 (be = 4'hF), then load the same address, WAIT_STATES = 2 -> each ack 3 cycles after acceptance; load rdata = 32'hDEADBEEF, err = 0.
- Partial store: store 32'h11223344 with be = 4'b0101 over word 32'hFFFFFFFF at 32'h10010000 -> reload gives 32'hFF22FF44.
- Errors:
  - Load from 32'h10010002 -> err = 1, rdata = 0, ack one cycle after acceptance.
  - Store to 32'h10011000 (DEPTH_WORDS = 1024, out of range) -> err = 1; RAM is unchanged.
- LED register: store 32'h000000A5 to MMIO_BASE+4 with be[0] = 1 -> leds = 8'hA5 from the RESP cycle; a store with be[0] = 0 leaves leds = 8'hA5; load returns 32'h000000A5.
- Reset mid-store: assert reset during WAIT of a store to 32'h10010010 (prior value 0) -> no ack; a later load returns 0. Also run back-to-back requests with WAIT_STATES = 0 -> ack every 2nd cycle.
